// File: rtl/sram_arb_pkg.sv
// Shared types and default parameters for the SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic {PORT_A, PORT_B} sram_port_t;

  localparam int DEF_READ_LATENCY = 3;
  localparam int DEF_MAX_A_RUN    = 8;

endpackage

// File: rtl/sram_return_pipe.sv
// Read-return tracker: a shift register of {valid, port} that marks which
// requester owns the data arriving from the controller at the tail.
module sram_return_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  sram_port_t load_port,
  output logic       tail_valid,
  output sram_port_t tail_port
);

  logic [DEPTH-1:0] valid_q;
  sram_port_t       port_q [DEPTH];

  // Valid bits shift toward the tail; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= load_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Port tags travel alongside the valid bits; they only matter when valid.
  always_ff @(posedge clk) begin
    port_q[0] <= load_port;
    for (int i = 1; i < DEPTH; i++) begin
      port_q[i] <= port_q[i-1];
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_port  = port_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the SRAM controller. Port A (display fetch)
// has priority; port B gets a forced slot after MAX_A_RUN consecutive A
// grants unless A holds its lock. Commands are registered toward the
// controller and read data is steered back to the issuing port.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int MAX_A_RUN    = DEF_MAX_A_RUN
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        SRAM_ready,
  input  logic        A_req,
  input  logic [17:0] A_addr,
  input  logic        A_lock,
  output logic        A_gnt,
  output logic        A_rvalid,
  output logic [15:0] A_rdata,
  input  logic        B_req,
  input  logic        B_we,
  input  logic [17:0] B_addr,
  input  logic [15:0] B_wdata,
  output logic        B_gnt,
  output logic        B_rvalid,
  output logic [15:0] B_rdata,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int              RUN_W   = $clog2(MAX_A_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_A_RUN);

  logic [RUN_W-1:0] a_run;
  logic             force_b;
  logic             issue_read;
  sram_port_t       issue_port;
  logic             tail_valid;
  sram_port_t       tail_port;

  // Grant decision; Reset and a stalled controller block both ports.
  always_comb begin
    force_b    = B_req && !A_lock && (a_run == RUN_MAX);
    A_gnt      = !Reset && SRAM_ready && A_req && !force_b;
    B_gnt      = !Reset && SRAM_ready && B_req && (!A_req || force_b) && !A_lock;
    issue_read = A_gnt || (B_gnt && !B_we);
    issue_port = B_gnt ? PORT_B : PORT_A;
  end

  // Count A grants while B waits; saturates so a lock cannot wrap it.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      a_run <= '0;
    end else if (B_gnt || !B_req) begin
      a_run <= '0;
    end else if (A_gnt && (a_run != RUN_MAX)) begin
      a_run <= a_run + 1'b1;
    end
  end

  // Register the accepted command; idle cycles become harmless reads.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else begin
      SRAM_we_n <= 1'b1;
      if (A_gnt) begin
        SRAM_address <= A_addr;
      end else if (B_gnt) begin
        SRAM_address <= B_addr;
        SRAM_we_n    <= !B_we;
        if (B_we) begin
          SRAM_write_data <= B_wdata;
        end
      end
    end
  end

  sram_return_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_return_pipe (
    .clk       (Clock_50),
    .rst       (Reset),
    .load_valid(issue_read),
    .load_port (issue_port),
    .tail_valid(tail_valid),
    .tail_port (tail_port)
  );

  // Steer returning data to its owner; the other port keeps its last value.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      A_rvalid <= 1'b0;
      B_rvalid <= 1'b0;
      A_rdata  <= '0;
      B_rdata  <= '0;
    end else begin
      A_rvalid <= tail_valid && (tail_port == PORT_A);
      B_rvalid <= tail_valid && (tail_port == PORT_B);
      if (tail_valid && (tail_port == PORT_A)) begin
        A_rdata <= SRAM_read_data;
      end
      if (tail_valid && (tail_port == PORT_B)) begin
        B_rdata <= SRAM_read_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a random phase, with a
// per-cycle monitor comparing grants, commands and read returns against a
// reference model built from the priority rules and a simple memory array.
module tb_sram_port_arbiter;

  localparam int L    = 3;
  localparam int MAXR = 8;

  logic        Clock_50;
  logic        Reset;
  logic        SRAM_ready;
  logic        A_req;
  logic [17:0] A_addr;
  logic        A_lock;
  logic        A_gnt;
  logic        A_rvalid;
  logic [15:0] A_rdata;
  logic        B_req;
  logic        B_we;
  logic [17:0] B_addr;
  logic [15:0] B_wdata;
  logic        B_gnt;
  logic        B_rvalid;
  logic [15:0] B_rdata;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  sram_port_arbiter #(.READ_LATENCY(L), .MAX_A_RUN(MAXR)) dut (
    .Clock_50       (Clock_50),
    .Reset          (Reset),
    .SRAM_ready     (SRAM_ready),
    .A_req          (A_req),
    .A_addr         (A_addr),
    .A_lock         (A_lock),
    .A_gnt          (A_gnt),
    .A_rvalid       (A_rvalid),
    .A_rdata        (A_rdata),
    .B_req          (B_req),
    .B_we           (B_we),
    .B_addr         (B_addr),
    .B_wdata        (B_wdata),
    .B_gnt          (B_gnt),
    .B_rvalid       (B_rvalid),
    .B_rdata        (B_rdata),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data)
  );

  typedef struct {
    logic        port_b;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        q [$];
  logic [15:0] ref_mem  [logic [17:0]];
  logic [15:0] sram_mem [logic [17:0]];
  logic [15:0] rd_line  [$];

  int          ref_run = 0;
  logic [17:0] e_addr = '0;
  logic        e_wen = 1'b1;
  logic [15:0] e_wd = '0;
  logic [15:0] e_ard = '0;
  logic [15:0] e_brd = '0;
  logic        a_acc = 1'b0;
  logic        b_acc = 1'b0;

  int a_gnt_cnt = 0, b_gnt_cnt = 0, a_rv_cnt = 0, b_rv_cnt = 0, we_low_cnt = 0;

  initial begin
    Clock_50 = 1'b0;
    forever #5 Clock_50 = ~Clock_50;
  end

  always @(posedge Clock_50) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [17:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_read(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock_50);
    #1;
  endtask

  // Controller stand-in: samples the command mid-cycle and presents the read
  // data so that it is on SRAM_read_data just before the return edge.
  task automatic stub_step();
    if (cyc == 0) return;
    rd_line.push_back(sram_mem.exists(SRAM_address) ? sram_mem[SRAM_address]
                                                    : init_val(SRAM_address));
    if (!SRAM_we_n) sram_mem[SRAM_address] = SRAM_write_data;
    if (rd_line.size() >= L) SRAM_read_data = rd_line.pop_front();
  endtask

  task automatic monitor_step();
    logic ea, eb;
    exp_t e;
    if (cyc == 0) return;
    ea = 1'b0;
    eb = 1'b0;
    if (!Reset && SRAM_ready) begin
      if (A_lock)                         ea = A_req;
      else if (B_req && ref_run >= MAXR)  eb = 1'b1;
      else if (A_req)                     ea = 1'b1;
      else                                eb = B_req;
    end
    chk("a_gnt", 32'(A_gnt), 32'(ea));
    chk("b_gnt", 32'(B_gnt), 32'(eb));
    chk("sram_address", 32'(SRAM_address), 32'(e_addr));
    chk("sram_we_n", 32'(SRAM_we_n), 32'(e_wen));
    chk("sram_write_data", 32'(SRAM_write_data), 32'(e_wd));
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      if (e.port_b) e_brd = e.data;
      else          e_ard = e.data;
      chk("a_rvalid", 32'(A_rvalid), 32'(!e.port_b));
      chk("b_rvalid", 32'(B_rvalid), 32'(e.port_b));
    end else begin
      chk("a_rvalid_idle", 32'(A_rvalid), 32'(0));
      chk("b_rvalid_idle", 32'(B_rvalid), 32'(0));
    end
    chk("a_rdata", 32'(A_rdata), 32'(e_ard));
    chk("b_rdata", 32'(B_rdata), 32'(e_brd));

    a_gnt_cnt  += int'(A_gnt);
    b_gnt_cnt  += int'(B_gnt);
    a_rv_cnt   += int'(A_rvalid);
    b_rv_cnt   += int'(B_rvalid);
    we_low_cnt += int'(!SRAM_we_n);

    a_acc = ea;
    b_acc = eb;
    if (Reset) begin
      ref_run = 0;
      e_addr  = '0;
      e_wen   = 1'b1;
      e_wd    = '0;
      e_ard   = '0;
      e_brd   = '0;
      q.delete();
    end else begin
      if (eb || !B_req)              ref_run = 0;
      else if (ea && ref_run < MAXR) ref_run++;
      e_wen = 1'b1;
      if (ea) begin
        e_addr   = A_addr;
        e.port_b = 1'b0;
        e.data   = ref_read(A_addr);
        e.cyc    = cyc + 1 + L;
        q.push_back(e);
      end else if (eb) begin
        e_addr = B_addr;
        if (B_we) begin
          e_wen           = 1'b0;
          e_wd            = B_wdata;
          ref_mem[B_addr] = B_wdata;
        end else begin
          e.port_b = 1'b1;
          e.data   = ref_read(B_addr);
          e.cyc    = cyc + 1 + L;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic issue_a(input logic [17:0] addr);
    int n = 0;
    A_req  = 1'b1;
    A_addr = addr;
    do begin step(); n++; end while (!a_acc && n < 50);
    chk("a_accept_in_time", 32'(a_acc), 32'(1));
    A_req = 1'b0;
  endtask

  task automatic issue_b(input logic we, input logic [17:0] addr, input logic [15:0] data);
    int n = 0;
    B_req   = 1'b1;
    B_we    = we;
    B_addr  = addr;
    B_wdata = data;
    do begin step(); n++; end while (!b_acc && n < 50);
    chk("b_accept_in_time", 32'(b_acc), 32'(1));
    B_req = 1'b0;
  endtask

  // Requesters hold a request until accepted, then may start a new one.
  task automatic drive(input int pa, input int pb);
    if (a_acc) A_req = 1'b0;
    if (b_acc) B_req = 1'b0;
    if (!A_req && int'($urandom_range(0, 99)) < pa) begin
      A_req  = 1'b1;
      A_addr = 18'($urandom_range(0, 63));
    end
    if (!B_req && int'($urandom_range(0, 99)) < pb) begin
      B_req   = 1'b1;
      B_we    = 1'($urandom_range(0, 1));
      B_addr  = 18'($urandom_range(0, 63));
      B_wdata = 16'($urandom);
    end
  endtask

  task automatic run_tests();
    int a0, b0, ar0, br0, w0;

    // Reset with both requests high
    Reset = 1'b1; SRAM_ready = 1'b1; A_lock = 1'b0;
    A_req = 1'b1; A_addr = 18'h00100;
    B_req = 1'b1; B_we = 1'b0; B_addr = 18'h00200; B_wdata = 16'h0;
    repeat (2) step();
    chk("rst_a_gnt", 32'(A_gnt), 32'(0));
    chk("rst_b_gnt", 32'(B_gnt), 32'(0));
    chk("rst_we_n", 32'(SRAM_we_n), 32'(1));
    chk("rst_address", 32'(SRAM_address), 32'(0));
    Reset = 1'b0; A_req = 1'b0; B_req = 1'b0;
    step();

    // Single A read
    ref_mem[18'h00010]  = 16'hABCD;
    sram_mem[18'h00010] = 16'hABCD;
    ar0 = a_rv_cnt;
    issue_a(18'h00010);
    chk("t2_sram_address", 32'(SRAM_address), 32'(18'h00010));
    repeat (L + 2) step();
    chk("t2_a_rvalid_count", 32'(a_rv_cnt - ar0), 32'(1));
    chk("t2_a_rdata", 32'(A_rdata), 32'(16'hABCD));

    // Write then read back
    ar0 = a_rv_cnt; br0 = b_rv_cnt; w0 = we_low_cnt;
    issue_b(1'b1, 18'h1F000, 16'h1234);
    issue_b(1'b0, 18'h1F000, 16'h0000);
    repeat (L + 3) step();
    chk("t3_we_low_cycles", 32'(we_low_cnt - w0), 32'(1));
    chk("t3_b_rvalid_count", 32'(b_rv_cnt - br0), 32'(1));
    chk("t3_b_rdata", 32'(B_rdata), 32'(16'h1234));
    chk("t3_no_a_rvalid", 32'(a_rv_cnt - ar0), 32'(0));

    // Starvation relief: 8 A then 1 B, repeating
    a0 = a_gnt_cnt; b0 = b_gnt_cnt;
    for (int i = 0; i < 45; i++) begin drive(100, 100); step(); end
    chk("t4_a_grants", 32'(a_gnt_cnt - a0), 32'(40));
    chk("t4_b_grants", 32'(b_gnt_cnt - b0), 32'(5));
    A_req = 1'b0; B_req = 1'b0;
    repeat (L + 2) step();

    // Lock blocks B entirely; release lets B in immediately
    a0 = a_gnt_cnt; b0 = b_gnt_cnt;
    A_lock = 1'b1;
    for (int i = 0; i < 40; i++) begin drive(100, 100); step(); end
    chk("t5_locked_b_grants", 32'(b_gnt_cnt - b0), 32'(0));
    chk("t5_locked_a_grants", 32'(a_gnt_cnt - a0), 32'(40));
    drive(100, 100);
    A_lock = 1'b0;
    #1;
    chk("t5_release_b_gnt", 32'(B_gnt), 32'(1));
    chk("t5_release_a_gnt", 32'(A_gnt), 32'(0));
    step();
    A_req = 1'b0; B_req = 1'b0;
    repeat (L + 2) step();

    // Alternating A/B reads back to back
    ar0 = a_rv_cnt; br0 = b_rv_cnt;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        A_req = 1'b1; A_addr = 18'h00300 + 18'(i); B_req = 1'b0;
      end else begin
        B_req = 1'b1; B_we = 1'b0; B_addr = 18'h00300 + 18'(i); A_req = 1'b0;
      end
      step();
    end
    A_req = 1'b0; B_req = 1'b0;
    repeat (L + 2) step();
    chk("t6_a_returns", 32'(a_rv_cnt - ar0), 32'(8));
    chk("t6_b_returns", 32'(b_rv_cnt - br0), 32'(8));

    // Reset with two reads in flight
    ar0 = a_rv_cnt; br0 = b_rv_cnt;
    A_req = 1'b1; A_addr = 18'h00400; step();
    A_req = 1'b0; B_req = 1'b1; B_we = 1'b0; B_addr = 18'h00401; step();
    B_req = 1'b0; Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    repeat (L + 4) step();
    chk("t6_flush_a_rvalid", 32'(a_rv_cnt - ar0), 32'(0));
    chk("t6_flush_b_rvalid", 32'(b_rv_cnt - br0), 32'(0));

    // Random traffic with stalls and lock toggling
    for (int i = 0; i < 400; i++) begin
      drive(60, 60);
      SRAM_ready = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 99) < 8) A_lock = !A_lock;
      step();
    end
    A_req = 1'b0; B_req = 1'b0; A_lock = 1'b0; SRAM_ready = 1'b1;
    repeat (L + 3) step();
    chk("pending_returns", 32'(q.size()), 32'(0));
  endtask

  initial begin
    Reset = 1'b1; SRAM_ready = 1'b1; A_lock = 1'b0;
    A_req = 1'b0; A_addr = '0; B_req = 1'b0; B_we = 1'b0; B_addr = '0; B_wdata = '0;
    fork
      forever begin @(negedge Clock_50); stub_step(); end
      forever begin @(negedge Clock_50); monitor_step(); end
      run_tests();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
